operand_sequencer: RTL and testbench

Input-side sequencer for the calculator datapath. It turns debounced `enter` button presses into one-cycle load strobes for the operand A, operand B and opcode storage registers. It also presents the captured value on a shared write bus and tracks which entry the user is expected to make next. It drives the load-enable (`retain`) inputs of the N-bit FDCE-style registers and sits between the debouncer/switch inputs and the operand register bank.

---
 rtl/operand_sequencer_if.sv | 31 +++
 rtl/operand_sequencer.sv | 86 ++++++++
 tb/tb_operand_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_if.sv
// Bundle between the switch/debouncer side and the operand register bank.
// Handshake: there is no back-pressure. A load strobe (load_a, load_b,
// load_op) is a one-cycle valid; wr_data is meaningful only while a strobe
// is high, and the receiving register is always ready to capture it.
interface operand_sequencer_if #(
   parameter int N     = 16,
   parameter int CNT_W = 8
);
   logic             enter_btn;
   logic             clear;
   logic [N-1:0]     data_in;
   logic             load_a;
   logic             load_b;
   logic             load_op;
   logic [N-1:0]     wr_data;
   logic             result_valid;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] seq_count;

   // Stimulus side: drives button, clear and switches; observes the sequencer.
   modport master (
      output enter_btn, clear, data_in,
      input  load_a, load_b, load_op, wr_data, result_valid, state_o, seq_count
   );

   // Sequencer side.
   modport slave (
      input  enter_btn, clear, data_in,
      output load_a, load_b, load_op, wr_data, result_valid, state_o, seq_count
   );
endinterface

// File: rtl/operand_sequencer.sv
// Turns rising edges of the debounced enter button into one-cycle load
// strobes for operand A, operand B and opcode, in that order, and presents
// the captured switch value on a registered write bus.
module operand_sequencer #(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   operand_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      WAIT_A      = 2'd0,
      WAIT_B      = 2'd1,
      WAIT_OP     = 2'd2,
      SHOW_RESULT = 2'd3
   } state_t;

   state_t           state;
   logic             enter_q;
   logic             press;
   logic             load_a_r;
   logic             load_b_r;
   logic             load_op_r;
   logic [N-1:0]     wr_data_r;
   logic [CNT_W-1:0] seq_count_r;

   // enter_q resets high so a button held through reset is not a press.
   assign press = bus.enter_btn & ~enter_q;

   // Sequencer state, edge detector, strobes, write bus and sequence counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_A;
         enter_q     <= 1'b1;
         load_a_r    <= 1'b0;
         load_b_r    <= 1'b0;
         load_op_r   <= 1'b0;
         wr_data_r   <= '0;
         seq_count_r <= '0;
      end else begin
         enter_q   <= bus.enter_btn;
         load_a_r  <= 1'b0;
         load_b_r  <= 1'b0;
         load_op_r <= 1'b0;
         if (bus.clear) begin
            // Abort: a press in this cycle is dropped; the count is kept.
            state     <= WAIT_A;
            wr_data_r <= '0;
         end else if (press) begin
            case (state)
               WAIT_A: begin
                  state     <= WAIT_B;
                  load_a_r  <= 1'b1;
                  wr_data_r <= bus.data_in;
               end
               WAIT_B: begin
                  state     <= WAIT_OP;
                  load_b_r  <= 1'b1;
                  wr_data_r <= bus.data_in;
               end
               WAIT_OP: begin
                  state       <= SHOW_RESULT;
                  load_op_r   <= 1'b1;
                  wr_data_r   <= bus.data_in;
                  seq_count_r <= seq_count_r + CNT_W'(1);
               end
               default: begin
                  // SHOW_RESULT: acknowledge and restart; write bus holds.
                  state <= WAIT_A;
               end
            endcase
         end
      end
   end

   assign bus.load_a       = load_a_r;
   assign bus.load_b       = load_b_r;
   assign bus.load_op      = load_op_r;
   assign bus.wr_data      = wr_data_r;
   assign bus.result_valid = (state == SHOW_RESULT);
   assign bus.state_o      = state;
   assign bus.seq_count    = seq_count_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: strobe expectations go into a queue
// when a press is driven; a negedge monitor pops one per observed strobe.
module tb_operand_sequencer;
   localparam int N     = 16;
   localparam int CNT_W = 8;
   localparam int W     = 3 + N + 2 + CNT_W;

   logic clk;
   logic reset;

   operand_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

   operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   logic [W-1:0]     exp_q[$];
   int               checks = 0;
   int               errors = 0;
   logic [1:0]       m_state;
   logic [CNT_W-1:0] m_count;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe seen must match the oldest queued expectation.
   initial begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (bus.load_a | bus.load_b | bus.load_op) begin
            got = {bus.load_op, bus.load_b, bus.load_a, bus.wr_data, bus.state_o, bus.seq_count};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got 0x%0h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL strobe: got 0x%0h expected 0x%0h", got, exp);
               end
            end
         end
      end
   end

   // Drivers
   task automatic push_exp(input logic [2:0] strb, input logic [N-1:0] d);
      exp_q.push_back({strb, d, m_state, m_count});
   endtask

   // Predict the press outcome and queue the strobe expectation (if any).
   task automatic predict(input logic [N-1:0] d);
      case (m_state)
         2'd0: begin m_state = 2'd1; push_exp(3'b001, d); end
         2'd1: begin m_state = 2'd2; push_exp(3'b010, d); end
         2'd2: begin m_state = 2'd3; m_count = m_count + 1'b1; push_exp(3'b100, d); end
         default: m_state = 2'd0;
      endcase
   endtask

   // One press: high for one sampled edge, then low; data_in is scrambled
   // in the strobe cycle to show the captured value is unaffected.
   task automatic do_press(input logic [N-1:0] d);
      @(negedge clk);
      bus.data_in   = d;
      bus.enter_btn = 1'b1;
      predict(d);
      @(negedge clk);
      bus.enter_btn = 1'b0;
      bus.data_in   = ~d;
      @(negedge clk);
      chk("state_o", 32'(bus.state_o), 32'(m_state));
      chk("result_valid", 32'(bus.result_valid), 32'(m_state == 2'd3));
   endtask

   task automatic apply_reset(input logic btn);
      @(negedge clk);
      reset = 1'b1;
      bus.enter_btn = btn;
      repeat (3) @(negedge clk);
      reset   = 1'b0;
      m_state = 2'd0;
      m_count = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(bus.state_o), 32'd0);
      chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_strobes"}, 32'({bus.load_op, bus.load_b, bus.load_a}), 32'd0);
      chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
      chk({tag, "_count"}, 32'(bus.seq_count), 32'd0);
   endtask

   // Stimulus
   initial begin
      reset         = 1'b1;
      bus.enter_btn = 1'b0;
      bus.clear     = 1'b0;
      bus.data_in   = '0;
      m_state       = 2'd0;
      m_count       = '0;

      // Reset state
      apply_reset(1'b0);
      @(negedge clk);
      chk_reset_vals("reset");

      // Basic A/B/OP sequence
      do_press(16'h0012);
      do_press(16'h0034);
      do_press(16'h0002);
      chk("seq1_count", 32'(bus.seq_count), 32'd1);
      chk("seq1_state", 32'(bus.state_o), 32'd3);

      // Press in SHOW_RESULT: back to WAIT_A, no strobe, wr_data holds
      do_press(16'h0099);
      chk("show_ack_wr_data", 32'(bus.wr_data), 32'h0002);

      // Held button in WAIT_A: exactly one load_a
      @(negedge clk);
      bus.data_in   = 16'h00AA;
      bus.enter_btn = 1'b1;
      predict(16'h00AA);
      repeat (20) @(negedge clk);
      bus.enter_btn = 1'b0;
      @(negedge clk);
      chk("hold_state", 32'(bus.state_o), 32'd1);

      // To WAIT_OP, then clear together with a press
      do_press(16'h00BB);
      @(negedge clk);
      bus.clear     = 1'b1;
      bus.enter_btn = 1'b1;
      bus.data_in   = 16'h0055;
      @(negedge clk);
      bus.clear     = 1'b0;
      bus.enter_btn = 1'b0;
      m_state       = 2'd0;
      chk("clear_state", 32'(bus.state_o), 32'd0);
      chk("clear_wr_data", 32'(bus.wr_data), 32'd0);
      chk("clear_count", 32'(bus.seq_count), 32'd1);
      chk("clear_load_op", 32'(bus.load_op), 32'd0);
      do_press(16'h0011);
      chk("after_clear_state", 32'(bus.state_o), 32'd1);

      // 256 full sequences: count wraps 255 -> 0
      apply_reset(1'b0);
      for (int i = 0; i < 256; i++) begin
         do_press(16'(i));
         do_press(16'(i + 1000));
         do_press(16'(i & 3));
         if (i == 254) chk("count_255", 32'(bus.seq_count), 32'd255);
         do_press(16'hFFFF);
      end
      chk("count_wrap", 32'(bus.seq_count), 32'd0);

      // Button held across reset release: no press until re-pressed
      apply_reset(1'b1);
      repeat (5) @(negedge clk);
      chk("held_reset_state", 32'(bus.state_o), 32'd0);
      bus.enter_btn = 1'b0;
      @(negedge clk);
      do_press(16'h0123);
      chk("held_reset_after", 32'(bus.state_o), 32'd1);

      // Reset right after a load_b press: all outputs back to reset values
      @(negedge clk);
      bus.data_in   = 16'h0456;
      bus.enter_btn = 1'b1;
      predict(16'h0456);
      @(negedge clk);
      reset         = 1'b1;
      bus.enter_btn = 1'b0;
      @(negedge clk);
      chk_reset_vals("mid_reset");
      reset   = 1'b0;
      m_state = 2'd0;
      m_count = '0;

      // Every queued strobe must have been seen
      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
